// File: rtl/gf180mcu_fd_sc_mcu9t5v0__clkdiv_drv_pkg.sv
// Shared definitions for the programmable glitch-free clock divider driving buf_4.
// Holds the FSM encoding, reset ratio and the period-boundary helper.
package gf180mcu_fd_sc_mcu9t5v0__clkdiv_drv_pkg;

  localparam int W_DEF       = 4;
  localparam int DIV_RST_DEF = 1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_RUN      = 2'b01,
    ST_STOPPING = 2'b10
  } state_e;

  // {z_q, z_d} pattern marking a period boundary (Z rising edge)
  localparam logic [1:0] Z_RISE = 2'b01;

  function automatic logic is_boundary(input logic z_now, input logic z_next);
    return ({z_now, z_next} == Z_RISE);
  endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__clkdiv_drv_if.sv
// Control/status bundle of the clock divider: run request, ratio load and outputs.
// The slave side is the divider; the master side is whoever programs it.
interface gf180mcu_fd_sc_mcu9t5v0__clkdiv_drv_if
  import gf180mcu_fd_sc_mcu9t5v0__clkdiv_drv_pkg::*;
#(
  parameter int W = W_DEF
);

  logic         EN;
  logic [W-1:0] DIV;
  logic         LD;
  logic         LD_ACK;
  logic         ACTIVE;
  logic         Z;

  modport master (
    output EN,
    output DIV,
    output LD,
    input  LD_ACK,
    input  ACTIVE,
    input  Z
  );

  modport slave (
    input  EN,
    input  DIV,
    input  LD,
    output LD_ACK,
    output ACTIVE,
    output Z
  );

endinterface

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__clkdiv_cnt.sv
// Phase counter of the clock divider: counts up, flags equality with the active
// ratio field and clears synchronously; the match-clear keeps it from wrapping.
module gf180mcu_fd_sc_mcu9t5v0__clkdiv_cnt
  import gf180mcu_fd_sc_mcu9t5v0__clkdiv_drv_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] div,
  output logic         match
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign match = (cnt_q == div);

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__clkdiv_drv.sv
// Programmable 50%-duty clock divider with clean stop; Z is a flop output feeding buf_4.
// Ratio loads are deferred to period boundaries (or applied at once while idle).
module gf180mcu_fd_sc_mcu9t5v0__clkdiv_drv
  import gf180mcu_fd_sc_mcu9t5v0__clkdiv_drv_pkg::*;
#(
  parameter int           W       = W_DEF,
  parameter logic [W-1:0] DIV_RST = W'(DIV_RST_DEF)
) (
  input  logic                                        CLK,
  input  logic                                        RN,
  gf180mcu_fd_sc_mcu9t5v0__clkdiv_drv_if.slave        dif
);

  state_e       state_q, state_d;
  logic         z_q, z_d;
  logic         active_q, active_d;
  logic         ld_ack_q, ld_ack_d;
  logic [W-1:0] div_q, div_d;
  logic [W-1:0] pend_q, pend_d;
  logic         pend_v_q, pend_v_d;
  logic         cnt_clr;
  logic         cnt_inc;
  logic         match;
  logic         apply;

  gf180mcu_fd_sc_mcu9t5v0__clkdiv_cnt #(.W(W)) u_cnt (
    .clk   (CLK),
    .rst_n (RN),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .div   (div_q),
    .match (match)
  );

  always_comb begin
    state_d  = state_q;
    z_d      = z_q;
    cnt_clr  = 1'b0;
    cnt_inc  = (state_q != ST_IDLE);
    unique case (state_q)
      ST_IDLE: begin
        cnt_clr = 1'b1;
        if (dif.EN) begin
          state_d = ST_RUN;
          z_d     = 1'b1;
        end
      end
      ST_RUN: begin
        if (!dif.EN && !z_q) begin
          state_d = ST_IDLE;
          cnt_clr = 1'b1;
        end else if (!dif.EN) begin
          // High phase already ending on this edge: finish it and go straight to idle
          if (match) begin
            z_d     = 1'b0;
            state_d = ST_IDLE;
            cnt_clr = 1'b1;
          end else begin
            state_d = ST_STOPPING;
          end
        end else if (match) begin
          z_d     = ~z_q;
          cnt_clr = 1'b1;
        end
      end
      ST_STOPPING: begin
        if (match) begin
          z_d     = 1'b0;
          state_d = ST_IDLE;
          cnt_clr = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        z_d     = 1'b0;
        cnt_clr = 1'b1;
      end
    endcase
  end

  always_comb begin
    div_d    = div_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    ld_ack_d = 1'b0;
    apply    = (state_q == ST_IDLE) || is_boundary(z_q, z_d);
    if (apply) begin
      // A strobe landing on the apply edge wins over any older pending value
      if (dif.LD) begin
        div_d    = dif.DIV;
        pend_v_d = 1'b0;
        ld_ack_d = 1'b1;
      end else if (pend_v_q) begin
        div_d    = pend_q;
        pend_v_d = 1'b0;
        ld_ack_d = 1'b1;
      end
    end else if (dif.LD) begin
      pend_d   = dif.DIV;
      pend_v_d = 1'b1;
    end
    active_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q  <= ST_IDLE;
      z_q      <= 1'b0;
      active_q <= 1'b0;
      ld_ack_q <= 1'b0;
      div_q    <= DIV_RST;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      z_q      <= z_d;
      active_q <= active_d;
      ld_ack_q <= ld_ack_d;
      div_q    <= div_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
    end
  end

  assign dif.Z      = z_q;
  assign dif.ACTIVE = active_q;
  assign dif.LD_ACK = ld_ack_q;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__clkdiv_drv.sv
// Directed self-checking bench for the clock divider; each task drives one scenario
// and compares Z / LD_ACK / ACTIVE after every rising edge against hand-derived vectors.
module tb_gf180mcu_fd_sc_mcu9t5v0__clkdiv_drv;

  logic clk;
  logic rn;
  int   checks   = 0;
  int   failures = 0;

  gf180mcu_fd_sc_mcu9t5v0__clkdiv_drv_if #(.W(4)) dif ();

  gf180mcu_fd_sc_mcu9t5v0__clkdiv_drv #(.W(4), .DIV_RST(4'd1)) dut (
    .CLK (clk),
    .RN  (rn),
    .dif (dif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit en, input bit ld, input logic [3:0] div);
    dif.EN  = en;
    dif.LD  = ld;
    dif.DIV = div;
    tick();
  endtask

  task automatic go_idle(input string tag);
    int n;
    n = 0;
    dif.EN = 1'b0;
    dif.LD = 1'b0;
    while (dif.ACTIVE !== 1'b0 && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (dif.ACTIVE !== 1'b0) begin
      failures++;
      $display("FAIL %s_go_idle: ACTIVE=%b after %0d cycles, required 0", tag, dif.ACTIVE, n);
    end
  endtask

  task automatic test_reset();
    bit z_v [8];
    z_v = '{1, 1, 0, 0, 1, 1, 0, 0};
    rn      = 1'b0;
    dif.EN  = 1'b1;
    dif.LD  = 1'b0;
    dif.DIV = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    checks += 3;
    if (dif.Z !== 1'b0) begin failures++; $display("FAIL reset_z: got %b want 0", dif.Z); end
    if (dif.ACTIVE !== 1'b0) begin failures++; $display("FAIL reset_active: got %b want 0", dif.ACTIVE); end
    if (dif.LD_ACK !== 1'b0) begin failures++; $display("FAIL reset_ack: got %b want 0", dif.LD_ACK); end
    @(negedge clk);
    rn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks += 2;
      if (dif.Z !== z_v[i]) begin
        failures++; $display("FAIL reset_pattern_z step %0d: got %b want %b", i, dif.Z, z_v[i]);
      end
      if (dif.ACTIVE !== 1'b1) begin
        failures++; $display("FAIL reset_pattern_active step %0d: got %b want 1", i, dif.ACTIVE);
      end
    end
    go_idle("reset");
  endtask

  task automatic test_extremes();
    bit         en_v  [6];
    bit         ld_v  [6];
    logic [3:0] div_v [6];
    bit         z_v   [6];
    bit         ack_v [6];
    bit         act_v [6];
    bit         zexp;
    en_v  = '{0, 1, 1, 1, 1, 1};
    ld_v  = '{1, 0, 0, 0, 1, 0};
    div_v = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd15, 4'd0};
    z_v   = '{0, 1, 0, 1, 0, 1};
    ack_v = '{1, 0, 0, 0, 0, 1};
    act_v = '{0, 1, 1, 1, 1, 1};
    for (int i = 0; i < 6; i++) begin
      drive(en_v[i], ld_v[i], div_v[i]);
      checks += 3;
      if (dif.Z !== z_v[i]) begin
        failures++; $display("FAIL extremes_z step %0d: got %b want %b", i, dif.Z, z_v[i]);
      end
      if (dif.LD_ACK !== ack_v[i]) begin
        failures++; $display("FAIL extremes_ack step %0d: got %b want %b", i, dif.LD_ACK, ack_v[i]);
      end
      if (dif.ACTIVE !== act_v[i]) begin
        failures++; $display("FAIL extremes_active step %0d: got %b want %b", i, dif.ACTIVE, act_v[i]);
      end
    end
    // Ratio 16: 15 more high samples, 16 low, then the next rise
    for (int k = 0; k < 32; k++) begin
      drive(1'b1, 1'b0, 4'd0);
      zexp = (k < 15) || (k == 31);
      checks += 2;
      if (dif.Z !== zexp) begin
        failures++; $display("FAIL extremes_r16_z k=%0d: got %b want %b", k, dif.Z, zexp);
      end
      if (dif.LD_ACK !== 1'b0) begin
        failures++; $display("FAIL extremes_r16_ack k=%0d: got %b want 0", k, dif.LD_ACK);
      end
    end
    go_idle("extremes");
  endtask

  task automatic test_clean_stop();
    bit en_v  [7];
    bit ld_v  [7];
    bit z_v   [7];
    bit ack_v [7];
    bit act_v [7];
    en_v  = '{0, 1, 0, 1, 1, 1, 0};
    ld_v  = '{1, 0, 0, 0, 0, 0, 0};
    z_v   = '{0, 1, 1, 1, 1, 0, 0};
    ack_v = '{1, 0, 0, 0, 0, 0, 0};
    act_v = '{0, 1, 1, 1, 1, 0, 0};
    for (int i = 0; i < 7; i++) begin
      drive(en_v[i], ld_v[i], 4'd3);
      checks += 3;
      if (dif.Z !== z_v[i]) begin
        failures++; $display("FAIL clean_stop_z step %0d: got %b want %b", i, dif.Z, z_v[i]);
      end
      if (dif.LD_ACK !== ack_v[i]) begin
        failures++; $display("FAIL clean_stop_ack step %0d: got %b want %b", i, dif.LD_ACK, ack_v[i]);
      end
      if (dif.ACTIVE !== act_v[i]) begin
        failures++; $display("FAIL clean_stop_active step %0d: got %b want %b", i, dif.ACTIVE, act_v[i]);
      end
    end
  endtask

  task automatic test_low_stop();
    bit en_v  [9];
    bit z_v   [9];
    bit act_v [9];
    en_v  = '{1, 1, 1, 1, 1, 1, 0, 0, 0};
    z_v   = '{1, 1, 1, 1, 0, 0, 0, 0, 0};
    act_v = '{1, 1, 1, 1, 1, 1, 0, 0, 0};
    for (int i = 0; i < 9; i++) begin
      drive(en_v[i], 1'b0, 4'd0);
      checks += 2;
      if (dif.Z !== z_v[i]) begin
        failures++; $display("FAIL low_stop_z step %0d: got %b want %b", i, dif.Z, z_v[i]);
      end
      if (dif.ACTIVE !== act_v[i]) begin
        failures++; $display("FAIL low_stop_active step %0d: got %b want %b", i, dif.ACTIVE, act_v[i]);
      end
    end
  endtask

  task automatic test_back_to_back_load();
    bit         ld_v  [24];
    logic [3:0] div_v [24];
    bit         z_v   [24];
    bit         ack_v [24];
    ld_v  = '{0,1,1,0, 0,0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,0, 1,0,0,0};
    div_v = '{0,5,2,0, 0,0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,0};
    z_v   = '{1,1,1,1, 0,0,0,0, 1,1,1,0, 0,0,1,1, 1,0,0,0, 1,0,1,0};
    ack_v = '{0,0,0,0, 0,0,0,0, 1,0,0,0, 0,0,0,0, 0,0,0,0, 1,0,0,0};
    for (int i = 0; i < 24; i++) begin
      drive(1'b1, ld_v[i], div_v[i]);
      checks += 3;
      if (dif.Z !== z_v[i]) begin
        failures++; $display("FAIL load_z step %0d: got %b want %b", i, dif.Z, z_v[i]);
      end
      if (dif.LD_ACK !== ack_v[i]) begin
        failures++; $display("FAIL load_ack step %0d: got %b want %b", i, dif.LD_ACK, ack_v[i]);
      end
      if (dif.ACTIVE !== 1'b1) begin
        failures++; $display("FAIL load_active step %0d: got %b want 1", i, dif.ACTIVE);
      end
    end
    go_idle("load");
  endtask

  task automatic test_async_reset();
    bit z_v [5];
    z_v = '{1, 1, 0, 0, 1};
    drive(1'b0, 1'b1, 4'd3);
    checks++;
    if (dif.LD_ACK !== 1'b1) begin failures++; $display("FAIL arst_setup_ack: got %b want 1", dif.LD_ACK); end
    drive(1'b1, 1'b0, 4'd0);
    drive(1'b1, 1'b0, 4'd0);
    drive(1'b1, 1'b1, 4'd7);
    checks++;
    if (dif.Z !== 1'b1) begin failures++; $display("FAIL arst_pre_z: got %b want 1", dif.Z); end
    dif.LD = 1'b0;
    dif.EN = 1'b0;
    #2 rn = 1'b0;
    #1;
    checks += 3;
    if (dif.Z !== 1'b0) begin failures++; $display("FAIL arst_z_async: got %b want 0", dif.Z); end
    if (dif.ACTIVE !== 1'b0) begin failures++; $display("FAIL arst_active_async: got %b want 0", dif.ACTIVE); end
    if (dif.LD_ACK !== 1'b0) begin failures++; $display("FAIL arst_ack_async: got %b want 0", dif.LD_ACK); end
    #1 rn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 4'd0);
      checks += 2;
      if (dif.LD_ACK !== 1'b0) begin
        failures++; $display("FAIL arst_no_ack step %0d: got %b want 0", i, dif.LD_ACK);
      end
      if (dif.Z !== 1'b0) begin
        failures++; $display("FAIL arst_idle_z step %0d: got %b want 0", i, dif.Z);
      end
    end
    // Period 4 after release proves the ratio reverted to the reset value
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 4'd0);
      checks += 2;
      if (dif.Z !== z_v[i]) begin
        failures++; $display("FAIL arst_period_z step %0d: got %b want %b", i, dif.Z, z_v[i]);
      end
      if (dif.LD_ACK !== 1'b0) begin
        failures++; $display("FAIL arst_period_ack step %0d: got %b want 0", i, dif.LD_ACK);
      end
    end
    go_idle("arst");
  endtask

  initial begin
    test_reset();
    test_extremes();
    test_clean_stop();
    test_low_stop();
    test_back_to_back_load();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gf180mcu_fd_sc_mcu9t5v0__clkdiv_drv.md
Name: gf180mcu_fd_sc_mcu9t5v0__clkdiv_drv

Overview:
- Programmable, glitch-free clock divider whose registered output Z drives the 4x buffer driver (buf_4) directly downstream, for local clock-tree branches.
- Output period is 2*(DIV+1) CLK cycles with 50% duty.
- Synchronous enable with clean stop: Z never produces a runt high pulse.
- Ratio changes are applied only at period boundaries and acknowledged with a single pulse.

Parameters:
- W, 4, width of the divide-ratio field; ratio R = DIV+1 ranges 1..2^W.
- DIV_RST, 1, ratio field value loaded at reset (R=2, output period 4 CLK).

Ports:
- CLK  input  1  clock, rising-edge.
- RN  input  1  asynchronous active-low reset.
- EN  input  1  run request, level-sensitive, sampled on CLK.
- DIV  input  W  new ratio field, valid when LD=1.
- LD  input  1  single-cycle load strobe for DIV.
- LD_ACK  output  1  one-cycle pulse when a loaded ratio takes effect.
- ACTIVE  output  1  high whenever the FSM is not IDLE.
- Z  output  1  divided clock, registered; feeds the buf_4 I pin.

Behaviour:
- Reset (RN=0, asynchronous):
  - Z=0, ACTIVE=0, LD_ACK=0.
  - state=IDLE, cnt=0, div_q=DIV_RST, pend_v=0.
  - On RN release, the first action occurs at the first CLK rise with RN=1.
- All outputs are registered; no combinational path from inputs to outputs.
- Internal state: cnt (W bits), div_q (active ratio), pend (pending ratio) with pend_v.
- FSM states: IDLE, RUN, STOPPING.
- IDLE:
  - Z=0, cnt=0.
  - EN=1 sampled → RUN; Z<=1 and cnt<=0 on the same edge. Latency from EN high to Z high is 1 CLK.
- RUN:
  - cnt increments each cycle.
  - When cnt==div_q: Z toggles and cnt<=0. Result: high for R cycles, low for R cycles.
  - EN=0 while Z=0 → IDLE next edge (truncating the low phase is allowed); Z stays 0, cnt<=0.
  - EN=0 while Z=1 → STOPPING; the high phase continues to completion.
- STOPPING:
  - cnt continues counting.
  - When cnt==div_q: Z<=0 → IDLE.
  - EN is ignored in this state. Restart needs EN=1 sampled in IDLE, so the minimum gap from Z fall to the next Z rise is 1 CLK.
- Period boundary: the edge at which Z goes 0→1, including the IDLE→RUN start.
- Ratio load:
  - LD=1 captures DIV into pend and sets pend_v.
  - In IDLE, a pending value applies on the next edge (div_q<=pend) and LD_ACK pulses on that edge.
  - Otherwise it applies at the next period boundary, with LD_ACK=1 for exactly the cycle following that edge.
  - A second LD while pend_v=1 overwrites pend. Only one LD_ACK is issued, for the last value.
  - LD on the same edge as an apply point: the incoming DIV bypasses pend, applies directly, and ACKs.
- Wrap/width:
  - cnt compares against div_q with a full W-bit equality check.
  - DIV=0 gives R=1: Z toggles every CLK, period 2.
  - DIV=2^W-1 gives R=2^W: no overflow, because cnt is cleared at the match.
- An RN assertion mid-period forces Z=0 immediately (asynchronously) and discards any pending load.

Decomposition:
- Shared package holds:
  - State encoding: IDLE=2'b00, RUN=2'b01, STOPPING=2'b10.
  - DIV_RST default value.
  - The period-boundary helper constant.
- Natural sub-module: gf180mcu_fd_sc_mcu9t5v0__clkdiv_cnt.
  - Contains the W-bit counter with match output and sync clear.
  - The top level keeps the FSM, load/pending logic and Z register.

Test Plan:
- Reset default: RN low then high, EN=1 held → Z rises 1 CLK after the first sampled EN; pattern is 2 high / 2 low (DIV_RST=1) repeating; ACTIVE=1.
- Extremes: LD with DIV=0 in IDLE, then EN=1 → LD_ACK pulse, then Z toggles every CLK. Then DIV=15 loaded mid-run → LD_ACK at the next Z rise, after which Z is 16 high / 16 low.
- Clean stop: DIV=3, drop EN at cycle 1 of the high phase → Z stays high for a full 4 cycles, falls, ACTIVE=0 the same edge. Raising EN during STOPPING does not extend Z.
- Low-phase stop: DIV=3, drop EN during the low phase → IDLE next edge, Z remains 0, no pulse emitted.
- Load collisions: LD DIV=5 then LD DIV=2 before the boundary → single LD_ACK, new period 6. LD coinciding with the boundary edge → bypass value applied and ACKed on that boundary.
- Async reset mid-high-phase with a pending load → Z=0 without waiting for CLK; after release, div_q=DIV_RST and no LD_ACK fires.
